// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one port of a block RAM among NUM_REQ requesters. Round-robin
// arbitration, valid/ready handshake, fixed one-cycle read response, and an
// optional lock for atomic read-modify-write sequences. A watchdog forcibly
// releases a lock that is held for LOCK_MAX cycles.
//
// state  | meaning
// -------+------------------------------------------------------------------
// ARB    | open arbitration, round-robin starting after rr_ptr
// LOCKED | only lock_owner may be granted; lock watchdog is running

module ram_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int WIDTHAD  = 16,
    parameter int WIDTH    = 32,
    parameter int LOCK_MAX = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*WIDTHAD-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_rdata,
    output logic [NUM_REQ-1:0]         lock_abort,
    output logic [WIDTHAD-1:0]         ram_address,
    output logic                       ram_wren,
    output logic [WIDTH-1:0]           ram_data,
    output logic                       ram_rden,
    input  logic [WIDTH-1:0]           ram_q
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(LOCK_MAX);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    // The watchdog counts down the locked cycles that remain before the
    // forced release; zero means this is the LOCK_MAX-th locked cycle.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_MAX - 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [TMR_W-1:0]   lock_tmr_q, lock_tmr_d;
    logic [NUM_REQ-1:0] rsp_pend_q, rsp_pend_d;

    logic [PTR_W-1:0]   winner;
    logic               found;
    int                 rr_idx;
    logic [PTR_W-1:0]   sel;
    logic               grant;

    // Round-robin search: first valid requester after rr_ptr, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[rr_idx]) begin
                found  = 1'b1;
                winner = PTR_W'(rr_idx);
            end
        end
    end

    // Grant selection; reset forces the port idle even while requests are up.
    always_comb begin
        sel   = winner;
        grant = 1'b0;
        if (!rst) begin
            if (state_q == LOCKED) begin
                sel   = owner_q;
                grant = req_valid[owner_q];
            end else begin
                sel   = winner;
                grant = found;
            end
        end
    end

    // RAM port drive and per-requester ready; everything is zero without a grant.
    always_comb begin
        req_ready   = '0;
        ram_wren    = 1'b0;
        ram_rden    = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        if (grant) begin
            req_ready[sel] = 1'b1;
            ram_wren       = req_we[sel];
            ram_rden       = !req_we[sel];
            ram_address    = req_addr[int'(sel)*WIDTHAD +: WIDTHAD];
            ram_data       = req_wdata[int'(sel)*WIDTH +: WIDTH];
        end
    end

    // Next-state logic for the lock FSM, round-robin pointer and read tracking.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_tmr_d = lock_tmr_q;
        rsp_pend_d = '0;
        lock_abort = '0;

        if (grant) begin
            rr_ptr_d = sel;
            if (!req_we[sel]) begin
                rsp_pend_d[sel] = 1'b1;
            end
        end

        case (state_q)
            ARB: begin
                if (grant && req_lock[sel]) begin
                    state_d    = LOCKED;
                    owner_d    = sel;
                    lock_tmr_d = TMR_LOAD;
                end
            end
            LOCKED: begin
                // Dropping lock ends ownership whether or not the owner is
                // making a final access this cycle (that access is granted).
                if (!req_lock[owner_q]) begin
                    state_d = ARB;
                end else if (lock_tmr_q == '0) begin
                    state_d             = ARB;
                    rr_ptr_d            = owner_q;
                    lock_abort[owner_q] = 1'b1;
                end else begin
                    lock_tmr_d = lock_tmr_q - 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State registers; reset drops any pending response and any lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            rr_ptr_q   <= PTR_LAST;
            owner_q    <= '0;
            lock_tmr_q <= '0;
            rsp_pend_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_tmr_q <= lock_tmr_d;
            rsp_pend_q <= rsp_pend_d;
        end
    end

    assign rsp_valid = rsp_pend_q;
    assign rsp_rdata = (|rsp_pend_q) ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM port and a
// response scoreboard.

module tb_ram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LM = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_we;
    logic [N-1:0]      req_lock;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [N-1:0]      lock_abort;
    logic [AW-1:0]     ram_address;
    logic              ram_wren;
    logic [DW-1:0]     ram_data;
    logic              ram_rden;
    logic [DW-1:0]     ram_q;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [N-1:0]  mask;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;
    rsp_t sb[$];

    ram_port_arbiter #(
        .NUM_REQ (N),
        .WIDTHAD (AW),
        .WIDTH   (DW),
        .LOCK_MAX(LM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .lock_abort (lock_abort),
        .ram_address(ram_address),
        .ram_wren   (ram_wren),
        .ram_data   (ram_data),
        .ram_rden   (ram_rden),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {16'hC0DE, a};
    endfunction

    // Behavioural RAM port: registered read, unwritten words hold init_val.
    logic [DW-1:0] mem [256];
    logic [255:0]  wr_ok = '0;
    logic [DW-1:0] q_r   = '0;
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_address[7:0]]   <= ram_data;
            wr_ok[ram_address[7:0]] <= 1'b1;
        end
        if (ram_rden) begin
            q_r <= wr_ok[ram_address[7:0]] ? mem[ram_address[7:0]] : init_val(ram_address);
        end
    end
    assign ram_q = q_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_lock[i]            = lk;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic push_rd(input logic [N-1:0] mask, input logic [DW-1:0] data);
        rsp_t e;
        e.mask = mask;
        e.data = data;
        e.due  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_idle_port(input string tag);
        chk({tag, "_ready"}, req_ready, 3'b000);
        chk({tag, "_wren"},  ram_wren, 1'b0);
        chk({tag, "_rden"},  ram_rden, 1'b0);
        chk({tag, "_addr"},  ram_address, 16'h0);
        chk({tag, "_data"},  ram_data, 32'h0);
    endtask

    // Response checker: every out-of-reset cycle, rsp_valid/rsp_rdata must
    // match the scoreboard entry due in this cycle, or be zero.
    always @(negedge clk) begin
        logic [N-1:0]  em;
        logic [DW-1:0] ed;
        if (!rst) begin
            em = '0;
            ed = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                em = sb[0].mask;
                ed = sb[0].data;
                void'(sb.pop_front());
            end
            chk("rsp_valid", rsp_valid, em);
            chk("rsp_rdata", rsp_rdata, ed);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [N-1:0] m;
        clear_all();

        // Reset state, including gating of live requests.
        sample();
        chk_idle_port("rst");
        chk("rst_rsp_valid", rsp_valid, 3'b000);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_abort", lock_abort, 3'b000);
        set_req(0, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0002, 32'h0);
        set_req(2, 1'b1, 1'b1, 1'b0, 16'h0003, 32'h1234);
        #1;
        chk_idle_port("rst_gated");
        clear_all();
        tick();
        rst = 1'b0;

        // Single write then read.
        set_req(0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'hDEADBEEF);
        sample();
        chk("t1_wr_ready", req_ready, 3'b001);
        chk("t1_wr_wren", ram_wren, 1'b1);
        chk("t1_wr_rden", ram_rden, 1'b0);
        chk("t1_wr_addr", ram_address, 16'h0010);
        chk("t1_wr_data", ram_data, 32'hDEADBEEF);
        tick();
        clear_all();
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
        push_rd(3'b010, 32'hDEADBEEF);
        sample();
        chk("t1_rd_ready", req_ready, 3'b010);
        chk("t1_rd_rden", ram_rden, 1'b1);
        chk("t1_rd_addr", ram_address, 16'h0010);
        tick();
        clear_all();
        sample();
        chk("t1_after_ready", req_ready, 3'b000);
        tick();

        // Requester 2 read so that rotation next starts at requester 0.
        set_req(2, 1'b1, 1'b0, 1'b0, 16'h0005, 32'h0);
        push_rd(3'b100, init_val(16'h0005));
        sample();
        chk("pre2_ready", req_ready, 3'b100);
        tick();
        clear_all();

        // Round-robin with all three continuously reading.
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, 1'b0, 1'b0, 16'h0001, 32'h0);
            set_req(1, 1'b1, 1'b0, 1'b0, 16'h0002, 32'h0);
            set_req(2, 1'b1, 1'b0, 1'b0, 16'h0003, 32'h0);
            m = 3'b001 << (k % 3);
            push_rd(m, init_val(16'(k % 3 + 1)));
            sample();
            chk("t2_ready", req_ready, m);
            chk("t2_addr", ram_address, 16'(k % 3 + 1));
            tick();
        end
        clear_all();

        // Requester 1 read so that rotation next starts at requester 2.
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0002, 32'h0);
        push_rd(3'b010, init_val(16'h0002));
        sample();
        chk("pre3_ready", req_ready, 3'b010);
        tick();
        clear_all();

        // Locked read-modify-write by requester 2 under contention.
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0001, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0002, 32'h0);
        set_req(2, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h0);
        push_rd(3'b100, init_val(16'h0020));
        sample();
        chk("t3_lock_rd_ready", req_ready, 3'b100);
        tick();
        set_req(2, 1'b0, 1'b0, 1'b1, 16'h0020, 32'h0);
        sample();
        chk("t3_locked_ready", req_ready, 3'b000);
        chk("t3_locked_rden", ram_rden, 1'b0);
        tick();
        set_req(2, 1'b1, 1'b1, 1'b0, 16'h0020, init_val(16'h0020) + 32'd1);
        sample();
        chk("t3_wr_ready", req_ready, 3'b100);
        chk("t3_wr_wren", ram_wren, 1'b1);
        chk("t3_wr_data", ram_data, init_val(16'h0020) + 32'd1);
        tick();
        set_req(2, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
        push_rd(3'b001, init_val(16'h0001));
        sample();
        chk("t3_after_ready0", req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
        push_rd(3'b010, init_val(16'h0002));
        sample();
        chk("t3_after_ready1", req_ready, 3'b010);
        tick();
        clear_all();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0);
        push_rd(3'b001, init_val(16'h0020) + 32'd1);
        sample();
        chk("t3_verify_ready", req_ready, 3'b001);
        tick();
        clear_all();

        // Lock watchdog: requester 1 locks then idles with lock held.
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0004, 32'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 16'h0006, 32'h0);
        push_rd(3'b010, init_val(16'h0004));
        sample();
        chk("t4_lock_ready", req_ready, 3'b010);
        chk("t4_lock_abort0", lock_abort, 3'b000);
        tick();
        set_req(1, 1'b0, 1'b0, 1'b1, 16'h0004, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            sample();
            chk("t4_held_ready", req_ready, 3'b000);
            chk("t4_held_abort", lock_abort, 3'b000);
            tick();
        end
        sample();
        chk("t4_abort_ready", req_ready, 3'b000);
        chk("t4_abort_pulse", lock_abort, 3'b010);
        tick();
        push_rd(3'b100, init_val(16'h0006));
        sample();
        chk("t4_next_ready", req_ready, 3'b100);
        chk("t4_next_abort", lock_abort, 3'b000);
        tick();
        set_req(2, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
        sample();
        chk("t4_nolock_ready", req_ready, 3'b000);
        chk("t4_nolock_abort", lock_abort, 3'b000);
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0008, 32'h0);
        push_rd(3'b001, init_val(16'h0008));
        sample();
        chk("t4_free_ready", req_ready, 3'b001);
        tick();
        clear_all();

        // Reset in the cycle after a locked read handshake.
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0007, 32'h0);
        sample();
        chk("t5_rd_ready", req_ready, 3'b010);
        tick();
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0001, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0002, 32'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 16'h0003, 32'h0);
        #1;
        chk("t5_async_rsp_valid", rsp_valid, 3'b000);
        chk("t5_async_rsp_rdata", rsp_rdata, 32'h0);
        chk("t5_async_abort", lock_abort, 3'b000);
        chk_idle_port("t5_async");
        sample();
        chk("t5_rst_rsp_valid", rsp_valid, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        push_rd(3'b001, init_val(16'h0001));
        sample();
        chk("t5_first_ready", req_ready, 3'b001);
        tick();
        clear_all();
        sample();
        tick();

        // Idle bus.
        for (int k = 0; k < 10; k++) begin
            sample();
            chk_idle_port("t6_idle");
            chk("t6_idle_abort", lock_abort, 3'b000);
            tick();
        end

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
